// File: rtl/layer1_feeder_pkg.sv
// Shared definitions for the layer-1 feeder: default lane geometry, the tap
// index width and the controller state encoding.
package layer1_feeder_pkg;

  localparam int LANES  = 10;  // pixel lanes presented to the MAC array
  localparam int DATA_W = 16;  // width of one pixel lane, the weight and one result lane
  localparam int TAP_W  = 8;   // tap index width; covers NUM_TAPS up to 255

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    CAPTURE,
    HOLD
  } state_e;

endpackage

// File: rtl/layer1_feeder_if.sv
// Result handshake between the feeder and whatever consumes the captured
// column of sums.
//   result       LANES*DATA_W  captured sums, lane 0 in the low bits
//   result_valid 1             result is held and may be taken
//   result_ready 1             consumer takes the result on valid && ready
interface layer1_feeder_if #(
  parameter int LANES  = layer1_feeder_pkg::LANES,
  parameter int DATA_W = layer1_feeder_pkg::DATA_W
) ();

  logic [LANES*DATA_W-1:0] result;
  logic                    result_valid;
  logic                    result_ready;

  modport master (
    output result,
    output result_valid,
    input  result_ready
  );

  modport slave (
    input  result,
    input  result_valid,
    output result_ready
  );

endinterface

// File: rtl/feeder_tap_counter.sv
// Tap counter for the RUN phase.
//   clk, reset  clock, asynchronous active-high reset
//   en          advance one tap this cycle
//   tap         current tap index, 0..NUM_TAPS-1
//   last        current tap is the final one
// The index returns to 0 after the last tap so every pass starts at tap 0.
module feeder_tap_counter #(
  parameter int NUM_TAPS = 9,
  parameter int TAP_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [TAP_W-1:0] tap,
  output logic             last
);

  logic [TAP_W-1:0] tap_q, tap_d;

  assign last = (tap_q == TAP_W'(NUM_TAPS - 1));
  assign tap  = tap_q;

  always_comb begin
    tap_d = tap_q;
    if (en) tap_d = last ? '0 : tap_q + TAP_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tap_q <= '0;
    else       tap_q <= tap_d;
  end

endmodule

// File: rtl/layer1_feeder.sv
// Layer-1 feeder: streams NUM_TAPS pixel/weight pairs from two memories into
// a MAC array, then captures the array's column of sums and offers it on a
// valid/ready handshake.
//   clk, reset         clock, asynchronous active-high reset
//   start              begin a pass (only honoured in IDLE)
//   px_base, w_base    first pixel/weight addresses, captured on start
//   px_addr, w_addr    memory read addresses (data returns one cycle later)
//   px_data, w_data    memory read data
//   pixels, weight     operands to the MAC array (zero outside RUN)
//   acc_clr            clears the MAC accumulators (CLEAR only)
//   column             accumulated sums from the MAC array
//   res_if             result / result_valid / result_ready handshake
//   busy               high in every state except IDLE
module layer1_feeder #(
  parameter int LANES    = layer1_feeder_pkg::LANES,
  parameter int DATA_W   = layer1_feeder_pkg::DATA_W,
  parameter int NUM_TAPS = 9,
  parameter int ADDR_W   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       px_base,
  input  logic [ADDR_W-1:0]       w_base,
  output logic [ADDR_W-1:0]       px_addr,
  output logic [ADDR_W-1:0]       w_addr,
  input  logic [LANES*DATA_W-1:0] px_data,
  input  logic [DATA_W-1:0]       w_data,
  output logic [LANES*DATA_W-1:0] pixels,
  output logic [DATA_W-1:0]       weight,
  output logic                    acc_clr,
  input  logic [LANES*DATA_W-1:0] column,
  layer1_feeder_if.master         res_if,
  output logic                    busy
);

  import layer1_feeder_pkg::*;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       px_base_q, px_base_d;
  logic [ADDR_W-1:0]       w_base_q, w_base_d;
  logic [LANES*DATA_W-1:0] result_q, result_d;

  logic [TAP_W-1:0]  tap_idx;
  logic              tap_last;
  logic              tap_en;
  logic [ADDR_W-1:0] tap_off;

  feeder_tap_counter #(
    .NUM_TAPS (NUM_TAPS),
    .TAP_W    (TAP_W)
  ) u_tap_counter (
    .clk   (clk),
    .reset (reset),
    .en    (tap_en),
    .tap   (tap_idx),
    .last  (tap_last)
  );

  // While tap i is consumed, fetch tap i+1. On the last tap the address stays
  // on the final operand, so nothing past the pass's window is ever read.
  assign tap_off = tap_last ? ADDR_W'(tap_idx) : ADDR_W'(tap_idx) + ADDR_W'(1);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    px_base_d = px_base_q;
    w_base_d  = w_base_q;
    result_d  = result_q;
    tap_en    = 1'b0;
    acc_clr   = 1'b0;
    pixels    = '0;
    weight    = '0;
    px_addr   = '0;
    w_addr    = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          px_base_d = px_base;
          w_base_d  = w_base;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        acc_clr = 1'b1;
        px_addr = px_base_q;
        w_addr  = w_base_q;
        state_d = RUN;
      end
      RUN: begin
        tap_en  = 1'b1;
        pixels  = px_data;
        weight  = w_data;
        px_addr = px_base_q + tap_off;
        w_addr  = w_base_q + tap_off;
        if (tap_last) state_d = CAPTURE;
      end
      CAPTURE: begin
        // The last product was accumulated on the edge that entered CAPTURE.
        result_d = column;
        state_d  = HOLD;
      end
      HOLD: begin
        if (res_if.result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      px_base_q <= '0;
      w_base_q  <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      px_base_q <= px_base_d;
      w_base_q  <= w_base_d;
      result_q  <= result_d;
    end
  end

  assign busy                = (state_q != IDLE);
  assign res_if.result_valid = (state_q == HOLD);
  assign res_if.result       = result_q;

endmodule

// File: tb/tb_layer1_feeder.sv
// Bench for layer1_feeder: three instances (9, 4 and 1 taps) share one pixel
// and one weight memory. Each instance has its own registered read port and
// its own MAC-array stand-in. Expected results come from a reference sum of
// products over the memory window.
module tb_layer1_feeder;

  localparam int LANES  = 10;
  localparam int DATA_W = 16;
  localparam int PW     = LANES * DATA_W;
  localparam int AW     = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0]     px_mem [256];
  logic [DATA_W-1:0] w_mem  [256];

  logic [2:0]             start_v;
  logic [2:0]             rready_v;
  logic [2:0][AW-1:0]     px_base_v, w_base_v;
  logic [2:0][AW-1:0]     px_addr_v, w_addr_v;
  logic [2:0][PW-1:0]     pixels_v, result_v;
  logic [2:0][DATA_W-1:0] weight_v;
  logic [2:0]             acc_clr_v, busy_v, rvalid_v;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NT = (g == 0) ? 9 : ((g == 1) ? 4 : 1);

    layer1_feeder_if #(.LANES(LANES), .DATA_W(DATA_W)) rif ();

    logic [PW-1:0]     px_q;
    logic [DATA_W-1:0] w_q;
    logic [PW-1:0]     acc_q, acc_n;

    assign rif.result_ready = rready_v[g];
    assign result_v[g]      = rif.result;
    assign rvalid_v[g]      = rif.result_valid;

    // Memories with one cycle of read latency.
    always_ff @(posedge clk) begin
      px_q <= px_mem[px_addr_v[g]];
      w_q  <= w_mem[w_addr_v[g]];
    end

    // MAC array stand-in: per-lane multiply-accumulate truncated to DATA_W.
    always_comb begin
      acc_n = acc_q;
      for (int k = 0; k < LANES; k++)
        acc_n[k*DATA_W +: DATA_W] = acc_q[k*DATA_W +: DATA_W]
                                  + pixels_v[g][k*DATA_W +: DATA_W] * weight_v[g];
    end
    always_ff @(posedge clk) acc_q <= acc_clr_v[g] ? '0 : acc_n;

    layer1_feeder #(
      .LANES    (LANES),
      .DATA_W   (DATA_W),
      .NUM_TAPS (NT),
      .ADDR_W   (AW)
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start_v[g]),
      .px_base (px_base_v[g]),
      .w_base  (w_base_v[g]),
      .px_addr (px_addr_v[g]),
      .w_addr  (w_addr_v[g]),
      .px_data (px_q),
      .w_data  (w_q),
      .pixels  (pixels_v[g]),
      .weight  (weight_v[g]),
      .acc_clr (acc_clr_v[g]),
      .column  (acc_q),
      .res_if  (rif.master),
      .busy    (busy_v[g])
    );
  end

  function automatic int nt_of(input int d);
    case (d)
      0:       return 9;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  // Reference: lane k = sum over taps of pixel[base+i][k] * weight[wbase+i], mod 2^DATA_W.
  function automatic logic [PW-1:0] model(input int nt, input logic [AW-1:0] pb,
                                          input logic [AW-1:0] wb);
    logic [PW-1:0]     r;
    logic [DATA_W-1:0] s;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      s = '0;
      for (int i = 0; i < nt; i++)
        s = s + px_mem[AW'(pb + i)][k*DATA_W +: DATA_W] * w_mem[AW'(wb + i)];
      r[k*DATA_W +: DATA_W] = s;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem();
    for (int a = 0; a < 256; a++) begin
      for (int k = 0; k < LANES; k++) px_mem[a][k*DATA_W +: DATA_W] = DATA_W'($urandom);
      w_mem[a] = DATA_W'($urandom);
    end
  endtask

  task automatic check_zero(input int d, input string when_s);
    check({when_s, "_result"},  result_v[d], '0);
    check({when_s, "_valid"},   PW'(rvalid_v[d]), '0);
    check({when_s, "_busy"},    PW'(busy_v[d]), '0);
    check({when_s, "_acc_clr"}, PW'(acc_clr_v[d]), '0);
    check({when_s, "_pixels"},  pixels_v[d], '0);
    check({when_s, "_weight"},  PW'(weight_v[d]), '0);
    check({when_s, "_px_addr"}, PW'(px_addr_v[d]), '0);
    check({when_s, "_w_addr"},  PW'(w_addr_v[d]), '0);
  endtask

  // Starts a pass at a negedge in IDLE and returns at the negedge of the
  // first HOLD cycle (or when the cycle budget runs out).
  task automatic run_pass(input int d, input logic [AW-1:0] pb, input logic [AW-1:0] wb,
                          output logic [PW-1:0] exp_o);
    int nt, n, clr;
    nt    = nt_of(d);
    exp_o = model(nt, pb, wb);
    start_v[d]   = 1'b1;
    px_base_v[d] = pb;
    w_base_v[d]  = wb;
    n   = 0;
    clr = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start_v[d] = 1'b0;
      clr += int'(acc_clr_v[d]);
      if (n <= nt) begin
        check("px_addr_seq", PW'(px_addr_v[d]), PW'(AW'(pb + n - 1)));
        check("w_addr_seq",  PW'(w_addr_v[d]),  PW'(AW'(wb + n - 1)));
      end
      if (n >= 2 && n <= nt + 1) begin
        check("pixels_feed", pixels_v[d], px_mem[AW'(pb + n - 2)]);
        check("weight_feed", PW'(weight_v[d]), PW'(w_mem[AW'(wb + n - 2)]));
      end
    end while (!rvalid_v[d] && n < 200);
    check("latency",        PW'(n),   PW'(nt + 3));
    check("result",         result_v[d], exp_o);
    check("acc_clr_pulses", PW'(clr), PW'(1));
    check("busy_in_hold",   PW'(busy_v[d]), PW'(1));
  endtask

  task automatic accept(input int d, input logic [PW-1:0] exp);
    rready_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready_v[d] = 1'b0;
    check("after_hs_valid",  PW'(rvalid_v[d]), '0);
    check("after_hs_busy",   PW'(busy_v[d]), '0);
    check("after_hs_result", result_v[d], exp);
  endtask

  initial begin
    logic [PW-1:0] exp, exp2, exp35;
    logic [AW-1:0] pb, wb;
    int            clr, seen, d, waitc;

    reset     = 1'b1;
    start_v   = '0;
    rready_v  = '0;
    px_base_v = '0;
    w_base_v  = '0;
    for (int a = 0; a < 256; a++) begin
      for (int k = 0; k < LANES; k++) px_mem[a][k*DATA_W +: DATA_W] = 16'h0001;
      w_mem[a] = 16'h0001;
    end

    // Reset state of every instance.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) check_zero(i, "reset");
    reset = 1'b0;
    @(negedge clk);

    // All ones, base 0: valid in cycle 12 with every lane 9.
    run_pass(0, 8'h00, 8'h00, exp);
    check("ones_lanes_9", result_v[0], {LANES{16'h0009}});

    // Ready held low for 5 cycles in HOLD with start pulsed meanwhile.
    clr = 0;
    for (int c = 0; c < 5; c++) begin
      start_v[0]   = (c == 1 || c == 2);
      px_base_v[0] = 8'h40;
      @(posedge clk);
      @(negedge clk);
      clr += int'(acc_clr_v[0]);
      check("hold_result", result_v[0], exp);
      check("hold_valid",  PW'(rvalid_v[0]), PW'(1));
      check("hold_busy",   PW'(busy_v[0]), PW'(1));
    end
    start_v[0] = 1'b0;
    check("hold_no_new_pass", PW'(clr), '0);
    accept(0, exp);

    // Reset in RUN at tap 4 abandons the pass.
    fill_mem();
    start_v[0]   = 1'b1;
    px_base_v[0] = 8'h10;
    w_base_v[0]  = 8'h20;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero(0, "abort");
    reset = 1'b0;
    seen  = 0;
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
      seen += int'(rvalid_v[0]);
    end
    check("abort_no_valid", PW'(seen), '0);
    run_pass(0, 8'h10, 8'h20, exp);
    accept(0, exp);

    // Ready in the first HOLD cycle, start in the following IDLE cycle.
    fill_mem();
    run_pass(0, 8'h33, 8'hC7, exp);
    accept(0, exp);
    run_pass(0, 8'hF9, 8'h05, exp2);
    accept(0, exp2);

    // Pixel addresses wrap: 0xFE, 0xFF, 0x00, 0x01 with 4 taps.
    fill_mem();
    run_pass(1, 8'hFE, 8'hFD, exp);
    accept(1, exp);

    // Single tap: lane k = k, weight 3 -> lane k = 3k, valid in cycle 4.
    for (int k = 0; k < LANES; k++) px_mem[8'h50][k*DATA_W +: DATA_W] = DATA_W'(k);
    w_mem[8'h60] = 16'd3;
    exp35 = '0;
    for (int k = 0; k < LANES; k++) exp35[k*DATA_W +: DATA_W] = DATA_W'(3 * k);
    run_pass(2, 8'h50, 8'h60, exp);
    check("one_tap_3k", result_v[2], exp35);
    accept(2, exp);

    // Randomized passes over all three instances with random ready delay.
    for (int it = 0; it < 6; it++) begin
      fill_mem();
      d  = int'($urandom_range(0, 2));
      pb = AW'($urandom);
      wb = AW'($urandom);
      run_pass(d, pb, wb, exp);
      waitc = int'($urandom_range(0, 3));
      for (int c = 0; c < waitc; c++) begin
        @(posedge clk);
        @(negedge clk);
        check("rand_hold_result", result_v[d], exp);
      end
      accept(d, exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
